// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment scan controller: digit_sel, seg and refresh_tick all change on the prescaler wrap edge.
// A value strobe shows up at the next units-digit start, so a tens/units pair always comes from one value.
module display_scan_ctrl #(
  parameter int CLK_HZ     = 100000000,
  parameter int REFRESH_HZ = 10000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] value_bin,
  input  logic       value_valid,
  output logic       digit_sel,
  output logic [6:0] seg,
  output logic       refresh_tick
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PW-1:0] prescaler;
  logic [3:0]    pending;
  logic [3:0]    shadow;
  logic [3:0]    shadow_nxt;
  logic [6:0]    seg_nxt;
  logic          wrap;
  logic          units_start;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign wrap        = (prescaler == TERM);
  assign units_start = wrap && digit_sel;

  // A strobe landing on the units-start edge bypasses pending so it is not delayed a full scan.
  always_comb begin
    shadow_nxt = shadow;
    if (units_start) begin
      shadow_nxt = value_valid ? value_bin : pending;
    end
  end

  // seg is computed for the digit that digit_sel is about to become.
  always_comb begin
    seg_nxt = SEG_BLANK;
    if (!digit_sel) begin
      if (shadow_nxt >= 4'd10) begin
        seg_nxt = seg_of(4'd1);
      end else if (!BLANK_LZ) begin
        seg_nxt = seg_of(4'd0);
      end
    end else begin
      seg_nxt = seg_of((shadow_nxt >= 4'd10) ? (shadow_nxt - 4'd10) : shadow_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      digit_sel    <= 1'b0;
      refresh_tick <= 1'b0;
      pending      <= 4'd0;
      shadow       <= 4'd0;
      seg          <= 7'b1000000;
    end else begin
      prescaler    <= wrap ? '0 : prescaler + PW'(1);
      refresh_tick <= wrap;
      shadow       <= shadow_nxt;
      if (value_valid) begin
        pending <= value_bin;
      end
      if (wrap) begin
        digit_sel <= ~digit_sel;
        seg       <= seg_nxt;
      end
    end
  end

endmodule
